// File: rtl/spiking_systolic_array_2x2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spiking_systolic_array_2x2_pkg
// Description : Shared sizing constants and helpers for the 2x2 spiking array.
// Revision    : 1.0 - initial release
// ============================================================================
package spiking_systolic_array_2x2_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int FIFO_DEPTH = 8;
    localparam int ARRAY_DIM  = 2;

    // Width of an index into n entries; never less than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spiking_systolic_array_2x2_spike_fifo.sv
`default_nettype none
// ============================================================================
// Module      : spike_fifo
// Description : Synchronous FIFO with a registered, zero-when-idle output.
// Revision    : 1.0 - initial release
// ============================================================================
module spike_fifo
#(
    parameter int WIDTH = 1,
    parameter int DEPTH = spiking_systolic_array_2x2_pkg::FIFO_DEPTH
)
(
    input  logic             clk,
    input  logic             rstn,
    input  logic             w_en_i,
    input  logic             r_en_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o
);
    import spiking_systolic_array_2x2_pkg::*;

    localparam int PTR_W = idx_width(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] C_LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] C_FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] dout_q, dout_d;

    logic w_empty;
    logic w_full;
    logic w_do_rd;
    logic w_do_wr;

    assign w_empty = (count_q == '0);
    assign w_full  = (count_q == C_FULL_CNT);
    assign w_do_rd = r_en_i && !w_empty;
    // A pop in the same cycle frees the slot, so a write to a full FIFO still lands.
    assign w_do_wr = w_en_i && (!w_full || w_do_rd);

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        dout_d  = '0;
        if (w_do_wr) begin
            wptr_d = (wptr_q == C_LAST_PTR) ? '0 : wptr_q + 1'b1;
        end
        if (w_do_rd) begin
            rptr_d = (rptr_q == C_LAST_PTR) ? '0 : rptr_q + 1'b1;
            dout_d = mem_q[rptr_q];
        end
        case ({w_do_wr, w_do_rd})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            dout_q  <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            dout_q  <= dout_d;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            mem_q[wptr_q] <= din_i;
        end
    end

    assign dout_o = dout_q;

endmodule
`default_nettype wire

// File: rtl/spiking_systolic_array_2x2.sv
`default_nettype none
// ============================================================================
// Module      : spiking_systolic_array_2x2
// Description : 2x2 spike-gated systolic MAC array fed by row/column FIFOs.
// Revision    : 1.0 - initial release
// ============================================================================
module spiking_systolic_array_2x2
#(
    parameter int DATA_WIDTH = spiking_systolic_array_2x2_pkg::DATA_WIDTH,
    parameter int FIFO_DEPTH = spiking_systolic_array_2x2_pkg::FIFO_DEPTH
)
(
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         row_fifo_0_w_en,
    input  logic                         row_fifo_1_w_en,
    input  logic                         row_fifo_0_r_en,
    input  logic                         row_fifo_1_r_en,
    input  logic                         col_fifo_0_w_en,
    input  logic                         col_fifo_1_w_en,
    input  logic                         col_fifo_0_r_en,
    input  logic                         col_fifo_1_r_en,
    input  logic                         in_row_0,
    input  logic                         in_row_1,
    input  logic signed [DATA_WIDTH-1:0] in_col_0,
    input  logic signed [DATA_WIDTH-1:0] in_col_1,
    output logic signed [DATA_WIDTH-1:0] out_data_0_0,
    output logic signed [DATA_WIDTH-1:0] out_data_0_1,
    output logic signed [DATA_WIDTH-1:0] out_data_1_0,
    output logic signed [DATA_WIDTH-1:0] out_data_1_1
);
    import spiking_systolic_array_2x2_pkg::*;

    logic [ARRAY_DIM-1:0]          w_row_wen;
    logic [ARRAY_DIM-1:0]          w_row_ren;
    logic [ARRAY_DIM-1:0]          w_row_din;
    logic [ARRAY_DIM-1:0]          w_row_dout;
    logic [ARRAY_DIM-1:0]          w_col_wen;
    logic [ARRAY_DIM-1:0]          w_col_ren;
    logic signed [DATA_WIDTH-1:0]  w_col_din  [ARRAY_DIM];
    logic signed [DATA_WIDTH-1:0]  w_col_dout [ARRAY_DIM];

    logic                          w_spike_in  [ARRAY_DIM][ARRAY_DIM];
    logic signed [DATA_WIDTH-1:0]  w_weight_in [ARRAY_DIM][ARRAY_DIM];
    logic                          w_spike_out [ARRAY_DIM][ARRAY_DIM];
    logic signed [DATA_WIDTH-1:0]  w_weight_out[ARRAY_DIM][ARRAY_DIM];
    logic signed [DATA_WIDTH-1:0]  w_acc       [ARRAY_DIM][ARRAY_DIM];

    assign w_row_wen     = {row_fifo_1_w_en, row_fifo_0_w_en};
    assign w_row_ren     = {row_fifo_1_r_en, row_fifo_0_r_en};
    assign w_row_din     = {in_row_1, in_row_0};
    assign w_col_wen     = {col_fifo_1_w_en, col_fifo_0_w_en};
    assign w_col_ren     = {col_fifo_1_r_en, col_fifo_0_r_en};
    assign w_col_din[0]  = in_col_0;
    assign w_col_din[1]  = in_col_1;

    generate
        for (genvar gr = 0; gr < ARRAY_DIM; gr++) begin : g_row_fifo
            spike_fifo #(
                .WIDTH (1),
                .DEPTH (FIFO_DEPTH)
            ) u_row_fifo (
                .clk    (clk),
                .rstn   (rstn),
                .w_en_i (w_row_wen[gr]),
                .r_en_i (w_row_ren[gr]),
                .din_i  (w_row_din[gr]),
                .dout_o (w_row_dout[gr])
            );
        end

        for (genvar gc = 0; gc < ARRAY_DIM; gc++) begin : g_col_fifo
            spike_fifo #(
                .WIDTH (DATA_WIDTH),
                .DEPTH (FIFO_DEPTH)
            ) u_col_fifo (
                .clk    (clk),
                .rstn   (rstn),
                .w_en_i (w_col_wen[gc]),
                .r_en_i (w_col_ren[gc]),
                .din_i  (w_col_din[gc]),
                .dout_o (w_col_dout[gc])
            );
        end

        // Spikes travel east along a row, weights travel south down a column.
        for (genvar gi = 0; gi < ARRAY_DIM; gi++) begin : g_pe_row
            for (genvar gj = 0; gj < ARRAY_DIM; gj++) begin : g_pe_col
                logic                         spike_q;
                logic signed [DATA_WIDTH-1:0] weight_q;
                logic signed [DATA_WIDTH-1:0] acc_q;
                logic signed [DATA_WIDTH-1:0] acc_d;

                if (gj == 0) begin : g_spike_edge
                    assign w_spike_in[gi][gj] = w_row_dout[gi];
                end else begin : g_spike_chain
                    assign w_spike_in[gi][gj] = w_spike_out[gi][gj-1];
                end

                if (gi == 0) begin : g_weight_edge
                    assign w_weight_in[gi][gj] = w_col_dout[gj];
                end else begin : g_weight_chain
                    assign w_weight_in[gi][gj] = w_weight_out[gi-1][gj];
                end

                always_comb begin
                    acc_d = acc_q;
                    if (w_spike_in[gi][gj]) begin
                        acc_d = acc_q + w_weight_in[gi][gj];
                    end
                end

                always_ff @(posedge clk or negedge rstn) begin
                    if (!rstn) begin
                        spike_q  <= 1'b0;
                        weight_q <= '0;
                        acc_q    <= '0;
                    end else begin
                        spike_q  <= w_spike_in[gi][gj];
                        weight_q <= w_weight_in[gi][gj];
                        acc_q    <= acc_d;
                    end
                end

                assign w_spike_out[gi][gj]  = spike_q;
                assign w_weight_out[gi][gj] = weight_q;
                assign w_acc[gi][gj]        = acc_q;
            end
        end
    endgenerate

    assign out_data_0_0 = w_acc[0][0];
    assign out_data_0_1 = w_acc[0][1];
    assign out_data_1_0 = w_acc[1][0];
    assign out_data_1_1 = w_acc[1][1];

endmodule
`default_nettype wire

// File: tb/tb_spiking_systolic_array_2x2.sv
`default_nettype none
// ============================================================================
// Module      : tb_spiking_systolic_array_2x2
// Description : Self-checking bench: queue-based FIFO model plus closed-form
//               delayed-product accumulation, with literal anchor checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spiking_systolic_array_2x2;

    localparam int DEPTH = 8;

    logic clk;
    logic rstn;
    logic rw0, rw1, rr0, rr1, cw0, cw1, cr0, cr1;
    logic ir0, ir1;
    logic signed [15:0] ic0, ic1;
    logic signed [15:0] o00, o01, o10, o11;

    spiking_systolic_array_2x2 dut (
        .clk             (clk),
        .rstn            (rstn),
        .row_fifo_0_w_en (rw0),
        .row_fifo_1_w_en (rw1),
        .row_fifo_0_r_en (rr0),
        .row_fifo_1_r_en (rr1),
        .col_fifo_0_w_en (cw0),
        .col_fifo_1_w_en (cw1),
        .col_fifo_0_r_en (cr0),
        .col_fifo_1_r_en (cr1),
        .in_row_0        (ir0),
        .in_row_1        (ir1),
        .in_col_0        (ic0),
        .in_col_1        (ic1),
        .out_data_0_0    (o00),
        .out_data_0_1    (o01),
        .out_data_1_0    (o10),
        .out_data_1_1    (o11)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // FIFOs are plain queues; PE(i,j) at an edge adds weight C_j popped i+1
    // edges earlier whenever row spike R_i popped j+1 edges earlier is set.
    bit                 rq0[$], rq1[$];
    logic signed [15:0] cq0[$], cq1[$];
    bit                 rh[2][2];
    logic signed [15:0] ch[2][2];
    logic signed [15:0] macc[2][2];
    logic signed [15:0] dout[2][2];

    int  npass = 0;
    int  ntot  = 0;
    bit  chk_en = 1'b0;

    task automatic model_clear();
        rq0.delete(); rq1.delete(); cq0.delete(); cq1.delete();
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) begin
                rh[i][j] = 1'b0; ch[i][j] = '0; macc[i][j] = '0;
            end
    endtask

    initial model_clear();

    always @(posedge clk or negedge rstn) begin
        bit                 rp[2];
        logic signed [15:0] cp[2];
        if (!rstn) begin
            model_clear();
        end else begin
            for (int i = 0; i < 2; i++)
                for (int j = 0; j < 2; j++)
                    if (rh[i][j]) macc[i][j] = macc[i][j] + ch[j][i];
            rp[0] = 1'b0; rp[1] = 1'b0; cp[0] = '0; cp[1] = '0;
            if (rr0 && rq0.size() > 0) rp[0] = rq0.pop_front();
            if (rr1 && rq1.size() > 0) rp[1] = rq1.pop_front();
            if (cr0 && cq0.size() > 0) cp[0] = cq0.pop_front();
            if (cr1 && cq1.size() > 0) cp[1] = cq1.pop_front();
            if (rw0 && rq0.size() < DEPTH) rq0.push_back(ir0);
            if (rw1 && rq1.size() < DEPTH) rq1.push_back(ir1);
            if (cw0 && cq0.size() < DEPTH) cq0.push_back(ic0);
            if (cw1 && cq1.size() < DEPTH) cq1.push_back(ic1);
            for (int k = 0; k < 2; k++) begin
                rh[k][1] = rh[k][0]; rh[k][0] = rp[k];
                ch[k][1] = ch[k][0]; ch[k][0] = cp[k];
            end
        end
    end

    assign dout[0][0] = o00;
    assign dout[0][1] = o01;
    assign dout[1][0] = o10;
    assign dout[1][1] = o11;

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++)
                for (int j = 0; j < 2; j++) begin
                    ntot++;
                    if (dout[i][j] === macc[i][j]) npass++;
                    else $display("FAIL model out_%0d_%0d @%0t: got %0d expected %0d",
                                  i, j, $time, dout[i][j], macc[i][j]);
                end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        rw0 = 0; rw1 = 0; rr0 = 0; rr1 = 0;
        cw0 = 0; cw1 = 0; cr0 = 0; cr1 = 0;
        ir0 = 0; ir1 = 0; ic0 = '0; ic1 = '0;
    endtask

    task automatic read_all(input int n);
        idle();
        rr0 = 1; rr1 = 1; cr0 = 1; cr1 = 1;
        repeat (n) tick();
        idle();
        tick();
    endtask

    task automatic check_lit(input string nm, input logic signed [15:0] got,
                             input logic signed [15:0] exp);
        ntot++;
        if (got === exp) npass++;
        else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    endtask

    task automatic check4(input string tag, input logic signed [15:0] e00,
                          input logic signed [15:0] e01, input logic signed [15:0] e10,
                          input logic signed [15:0] e11);
        check_lit({tag, " out_0_0"}, o00, e00);
        check_lit({tag, " out_0_1"}, o01, e01);
        check_lit({tag, " out_1_0"}, o10, e10);
        check_lit({tag, " out_1_1"}, o11, e11);
    endtask

    task automatic do_reset(input string tag);
        rstn = 1'b0;
        #1;
        check4({tag, " async reset"}, 16'sd0, 16'sd0, 16'sd0, 16'sd0);
        idle();
        tick();
        tick();
        rstn = 1'b1;
        tick();
    endtask

    task automatic run_matmul();
        bit                 r0v[3];
        bit                 r1v[3];
        logic signed [15:0] c0v[3];
        logic signed [15:0] c1v[3];
        r0v = '{1'b1, 1'b0, 1'b0};
        r1v = '{1'b0, 1'b1, 1'b1};
        c0v = '{16'sd14, -16'sd21, 16'sd0};
        c1v = '{16'sd0, 16'sd23, -16'sd30};
        for (int k = 0; k < 3; k++) begin
            idle();
            rw0 = 1; rw1 = 1; cw0 = 1; cw1 = 1;
            ir0 = r0v[k]; ir1 = r1v[k]; ic0 = c0v[k]; ic1 = c1v[k];
            tick();
        end
        read_all(5);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        idle();
        rstn = 1'b0;
        tick();
        tick();
        check4("power-on reset", 16'sd0, 16'sd0, 16'sd0, 16'sd0);
        chk_en = 1'b1;
        rstn = 1'b1;
        tick();

        run_matmul();
        check4("matmul", 16'sd14, 16'sd23, -16'sd7, -16'sd7);
        run_matmul();
        check4("matmul x2", 16'sd28, 16'sd46, -16'sd14, -16'sd14);

        do_reset("mid-run");
        read_all(3);
        check4("read empty", 16'sd0, 16'sd0, 16'sd0, 16'sd0);

        // Three spikes of 16384 wrap PE(0,0) to -16384.
        for (int k = 0; k < 3; k++) begin
            idle();
            rw0 = 1; cw0 = 1; ir0 = 1; ic0 = 16'sd16384;
            tick();
        end
        read_all(5);
        check_lit("overflow wrap out_0_0", o00, -16'sd16384);

        // Nine pushes into depth-8 FIFOs: ninth is dropped, eight weights of 1 summed.
        do_reset("pre-full");
        for (int k = 0; k < 9; k++) begin
            idle();
            rw0 = 1; cw0 = 1; ir0 = 1; ic0 = 16'sd1;
            tick();
        end
        read_all(12);
        check_lit("full fifo drop out_0_0", o00, 16'sd8);

        // Weights but no spikes must leave every accumulator at zero.
        do_reset("pre-nospike");
        repeat (30) begin
            rw0 = 1'($urandom); rw1 = 1'($urandom); rr0 = 1'($urandom); rr1 = 1'($urandom);
            cw0 = 1'($urandom); cw1 = 1'($urandom); cr0 = 1'($urandom); cr1 = 1'($urandom);
            ir0 = 0; ir1 = 0; ic0 = 16'($urandom); ic1 = 16'($urandom);
            tick();
        end
        read_all(10);
        check4("no spikes", 16'sd0, 16'sd0, 16'sd0, 16'sd0);

        // Random traffic exercises pointer wrap, full/empty concurrency and resets.
        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset("random");
            end else begin
                rw0 = ($urandom_range(0, 9) < 6); rw1 = ($urandom_range(0, 9) < 6);
                rr0 = ($urandom_range(0, 9) < 5); rr1 = ($urandom_range(0, 9) < 5);
                cw0 = ($urandom_range(0, 9) < 6); cw1 = ($urandom_range(0, 9) < 6);
                cr0 = ($urandom_range(0, 9) < 5); cr1 = ($urandom_range(0, 9) < 5);
                ir0 = 1'($urandom); ir1 = 1'($urandom);
                ic0 = 16'($urandom); ic1 = 16'($urandom);
                tick();
            end
        end
        idle();
        tick();
        chk_en = 1'b0;
        #1;
        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
`default_nettype wire
